// File: rtl/palette_host_sequencer.sv
// palette_host_sequencer
//   Host-side initiator for the palette RAM's 8-bit host port. The RAM holds
//   512 bytes, which the pixel port sees as 256 RGB565 entries. Each whole-entry
//   command becomes two byte accesses: the low byte at 2*index and the high byte
//   at 2*index+1. Read bytes are reassembled into a single 16-bit response.
//
// Ports
//   clk, reset_n         clock shared with the RAM host port; synchronous
//                        active-low reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready is high only in IDLE
//   cmd_write            1 = write entry, 0 = read entry
//   cmd_index            palette entry index
//   cmd_wdata            RGB565 write data (ignored for reads)
//   rsp_valid            one-cycle pulse marking valid read data
//   rsp_rdata            reassembled read data, held until the next read
//   host_address         RAM byte address
//   host_data_in         RAM write byte
//   host_enable          RAM host-port clock enable
//   host_wren            RAM host-port write enable
//   rden_b               RAM host-port read enable
//   host_data_out        registered RAM read byte

module palette_host_sequencer #(
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [7:0]  cmd_index,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic [8:0]  host_address,
  output logic [7:0]  host_data_in,
  output logic        host_enable,
  output logic        host_wren,
  output logic        rden_b,
  input  logic [7:0]  host_data_out
);

  typedef enum logic [2:0] {
    IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_WAIT, RSP
  } state_t;

  state_t      state;
  logic [7:0]  idx_q;
  logic [7:0]  wdata_hi_q;

  // Read-return tracking. Bit k is set when the byte requested k+1 cycles ago
  // was a read. rd_hi_p flags whether that byte was the high byte. A byte is on
  // host_data_out while the top bit is set.
  logic [RD_LAT-1:0] rd_vld_p;
  logic [RD_LAT-1:0] rd_hi_p;

  logic rd_cap;
  logic rd_cap_hi;

  assign rd_cap    = rd_vld_p[RD_LAT-1];
  assign rd_cap_hi = rd_vld_p[RD_LAT-1] & rd_hi_p[RD_LAT-1];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      host_address <= '0;
      host_data_in <= '0;
      host_enable  <= 1'b0;
      host_wren    <= 1'b0;
      rden_b       <= 1'b0;
      idx_q        <= '0;
      wdata_hi_q   <= '0;
      rd_vld_p     <= '0;
      rd_hi_p      <= '0;
    end else begin
      rd_vld_p  <= (rd_vld_p << 1) | RD_LAT'(rden_b);
      rd_hi_p   <= (rd_hi_p << 1) | RD_LAT'(rden_b & host_address[0]);
      rsp_valid <= 1'b0;

      if (rd_cap) begin
        if (rd_hi_p[RD_LAT-1]) rsp_rdata[15:8] <= host_data_out;
        else                   rsp_rdata[7:0]  <= host_data_out;
      end

      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready    <= 1'b0;
            idx_q        <= cmd_index;
            wdata_hi_q   <= cmd_wdata[15:8];
            host_address <= {cmd_index, 1'b0};
            host_enable  <= 1'b1;
            if (cmd_write) begin
              host_wren    <= 1'b1;
              host_data_in <= cmd_wdata[7:0];
              state        <= WR_LO;
            end else begin
              rden_b <= 1'b1;
              state  <= RD_LO;
            end
          end
        end
        WR_LO: begin
          host_address <= {idx_q, 1'b1};
          host_data_in <= wdata_hi_q;
          state        <= WR_HI;
        end
        WR_HI: begin
          host_enable <= 1'b0;
          host_wren   <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
        RD_LO: begin
          host_address <= {idx_q, 1'b1};
          state        <= RD_HI;
        end
        RD_HI: begin
          host_enable <= 1'b0;
          rden_b      <= 1'b0;
          state       <= RD_WAIT;
        end
        RD_WAIT: begin
          // The response is raised on the same edge that stores the high byte.
          if (rd_cap_hi) begin
            rsp_valid <= 1'b1;
            state     <= RSP;
          end
        end
        RSP: begin
          cmd_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          host_enable <= 1'b0;
          host_wren   <= 1'b0;
          rden_b      <= 1'b0;
          cmd_ready   <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_palette_host_sequencer.sv
module tb_palette_host_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_index;
  logic [15:0] cmd_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic [8:0]  host_address;
  logic [7:0]  host_data_in;
  logic        host_enable;
  logic        host_wren;
  logic        rden_b;
  logic [7:0]  host_data_out = 8'h00;

  palette_host_sequencer #(.RD_LAT(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_index(cmd_index), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .host_address(host_address), .host_data_in(host_data_in),
    .host_enable(host_enable), .host_wren(host_wren), .rden_b(rden_b),
    .host_data_out(host_data_out)
  );

  always #5 clk = ~clk;

  // Palette RAM host port: address registered into q_s1, then a second output
  // register, giving two cycles from address to byte.
  logic [7:0] mem [0:511] = '{default: 8'h00};
  logic [7:0] q_s1 = 8'h00;
  always @(posedge clk) begin
    if (host_enable && host_wren) mem[host_address] <= host_data_in;
    q_s1          <= (host_enable && rden_b) ? mem[host_address] : 8'h00;
    host_data_out <= q_s1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboards
  logic [15:0] model [0:255] = '{default: 16'h0000};
  logic [16:0] wr_q [$];   // {address, byte}
  logic [15:0] rd_q [$];
  int          cyc_q [$];

  int wren_cnt = 0, rden_cnt = 0, nrdy_cnt = 0, rsp_cnt = 0;

  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (host_wren) wren_cnt <= wren_cnt + 1;
      if (rden_b)    rden_cnt <= rden_cnt + 1;
      if (!cmd_ready) nrdy_cnt <= nrdy_cnt + 1;
      if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
      if (host_enable) chk("one_op_per_cycle", {31'd0, host_wren ^ rden_b}, 32'd1);
      else             chk("idle_ctrl", {30'd0, host_wren, rden_b}, 32'd0);
      if (host_enable && host_wren) begin
        if (wr_q.size() == 0) chk("unexpected_write", {31'd0, host_wren}, 32'd0);
        else chk("write_byte", {15'd0, host_address, host_data_in}, {15'd0, wr_q.pop_front()});
      end
      if (rsp_valid) begin
        if (rd_q.size() == 0) chk("unexpected_rsp", {31'd0, rsp_valid}, 32'd0);
        else begin
          chk("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, rd_q.pop_front()});
          chk("rsp_latency", cyc, cyc_q.pop_front() + 5);
        end
      end
    end
  end

  // Present a command and hold it until accepted; cmd_valid stays high after.
  task automatic do_cmd(input logic w, input logic [7:0] i, input logic [15:0] d);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_index = i; cmd_wdata = d;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("accept_timeout", {31'd0, cmd_ready}, 32'd1);
    else if (w) begin
      model[i] = d;
      wr_q.push_back({i, 1'b0, d[7:0]});
      wr_q.push_back({i, 1'b1, d[15:8]});
    end else begin
      rd_q.push_back(model[i]);
      cyc_q.push_back(cyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  int b_wr, b_rd, b_nr, b_rsp, n;

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_index = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {16'd0, rsp_rdata}, 32'd0);
    chk("rst_address", {23'd0, host_address}, 32'd0);
    chk("rst_data_in", {24'd0, host_data_in}, 32'd0);
    chk("rst_ctrl", {29'd0, host_enable, host_wren, rden_b}, 32'd0);
    @(posedge clk); #1;

    // Single write: two bytes, two wren cycles, two not-ready cycles
    b_wr = wren_cnt; b_nr = nrdy_cnt;
    do_cmd(1'b1, 8'h12, 16'hF81F);
    idle(4);
    chk("byte_024", {24'd0, mem[9'h024]}, 32'h1F);
    chk("byte_025", {24'd0, mem[9'h025]}, 32'hF8);
    chk("wren_cycles", wren_cnt - b_wr, 32'd2);
    chk("notready_cycles", nrdy_cnt - b_nr, 32'd2);

    // Read it back
    b_rd = rden_cnt; b_rsp = rsp_cnt;
    do_cmd(1'b0, 8'h12, 16'h0000);
    idle(8);
    chk("rden_cycles", rden_cnt - b_rd, 32'd2);
    chk("rsp_pulses", rsp_cnt - b_rsp, 32'd1);

    // Top entry, read straight after write
    do_cmd(1'b1, 8'hFF, 16'hABCD);
    do_cmd(1'b0, 8'hFF, 16'h0000);
    idle(8);
    chk("byte_510", {24'd0, mem[9'd510]}, 32'hCD);
    chk("byte_511", {24'd0, mem[9'd511]}, 32'hAB);
    chk("byte_000", {24'd0, mem[9'd0]}, 32'h00);
    chk("byte_001", {24'd0, mem[9'd1]}, 32'h00);

    // cmd_valid held high over alternating commands
    b_rsp = rsp_cnt;
    do_cmd(1'b1, 8'h30, 16'h1111);
    do_cmd(1'b0, 8'h30, 16'h0000);
    do_cmd(1'b1, 8'h31, 16'h2222);
    do_cmd(1'b0, 8'h31, 16'h0000);
    do_cmd(1'b0, 8'h12, 16'h0000);
    idle(10);
    chk("held_rsp_pulses", rsp_cnt - b_rsp, 32'd3);

    // Index 0
    do_cmd(1'b1, 8'h00, 16'h0BEE);
    do_cmd(1'b0, 8'h00, 16'h0000);
    idle(8);
    chk("byte_000_w", {24'd0, mem[9'd0]}, 32'hEE);
    chk("byte_001_w", {24'd0, mem[9'd1]}, 32'h0B);

    // Reset during RD_HI drops the response
    do_cmd(1'b1, 8'h50, 16'h7E57);
    do_cmd(1'b0, 8'h50, 16'h0000);
    cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!(rden_b && host_address[0]) && n < 20) begin @(negedge clk); n++; end
    chk("reach_rd_hi", {31'd0, rden_b & host_address[0]}, 32'd1);
    reset_n = 1'b0;
    void'(rd_q.pop_back());
    void'(cyc_q.pop_back());
    @(negedge clk);
    chk("midrst_ctrl", {29'd0, host_enable, host_wren, rden_b}, 32'd0);
    chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rdata", {16'd0, rsp_rdata}, 32'd0);
    reset_n = 1'b1;
    b_rsp = rsp_cnt;
    idle(6);
    chk("midrst_no_rsp", rsp_cnt - b_rsp, 32'd0);
    do_cmd(1'b0, 8'h50, 16'h0000);

    // Unwritten entry
    do_cmd(1'b0, 8'h40, 16'h0000);
    idle(10);

    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("wr_q_drained", wr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
